shift_left_unit: RTL and testbench

- Logical left-shift-by-one unit for the 16-bit datapath, used for sign-extended immediate/branch-offset scaling (×2).
- The combinational output `data_out` is available in the same cycle.
- A registered copy of the result and the shifted-out bit is provided for pipelined consumers.
- It sits between the immediate generator and the PC/ALU-B operand muxes.

---
 rtl/shift_left_unit.sv | 63 ++++++
 tb/tb_shift_left_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/shift_left_unit.sv
// rtl/shift_left_unit.sv - logical left shift by SHIFT with combinational and registered results
//
// Scales sign-extended immediates and branch offsets by 2^SHIFT between the
// immediate generator and the PC/ALU-B operand muxes.
//
// Ports:
//   clk          in   system clock, registered outputs update on rising edge
//   rst_n        in   asynchronous active-low reset, clears registered state
//   en           in   capture enable for the registered outputs
//   data_in      in   [WIDTH-1:0] unsigned operand
//   data_out     out  [WIDTH-1:0] data_in << SHIFT, zero-filled (combinational)
//   carry_out    out  [SHIFT-1:0] bits shifted out of the top (combinational)
//   data_out_q   out  [WIDTH-1:0] registered data_out
//   carry_out_q  out  [SHIFT-1:0] registered carry_out
//   valid_q      out  registered outputs hold a captured result
module shift_left_unit #(
   parameter int WIDTH = 16,
   parameter int SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [SHIFT-1:0] carry_out,
   output logic [WIDTH-1:0] data_out_q,
   output logic [SHIFT-1:0] carry_out_q,
   output logic             valid_q
);

   logic [WIDTH-1:0] data_out_d;
   logic [SHIFT-1:0] carry_out_d;
   logic             valid_d;

   // Pure wiring: the result is available in the same cycle and is independent
   // of reset and enable.
   assign data_out  = {data_in[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
   assign carry_out = data_in[WIDTH-1 -: SHIFT];

   always_comb begin
      data_out_d  = data_out_q;
      carry_out_d = carry_out_q;
      valid_d     = valid_q;
      if (en) begin
         data_out_d  = data_out;
         carry_out_d = carry_out;
         valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q  <= '0;
         carry_out_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         data_out_q  <= data_out_d;
         carry_out_q <= carry_out_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_shift_left_unit.sv
// tb/tb_shift_left_unit.sv - self-checking bench for shift_left_unit
module tb_shift_left_unit;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic [0:0]  carry_out;
   logic [15:0] data_out_q;
   logic [0:0]  carry_out_q;
   logic        valid_q;

   int errors = 0;
   int checks = 0;

   // reference register state
   int exp_q;
   int exp_cq;
   int exp_v;

   shift_left_unit #(.WIDTH(16), .SHIFT(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .data_in     (data_in),
      .data_out    (data_out),
      .carry_out   (carry_out),
      .data_out_q  (data_out_q),
      .carry_out_q (carry_out_q),
      .valid_q     (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_out(input int d);
      return (2 * d) % 65536;
   endfunction

   function automatic int model_carry(input int d);
      return (d >= 32768) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_comb(input string tag);
      check({tag, "_out"},   int'(data_out),  model_out(int'(data_in)));
      check({tag, "_carry"}, int'(carry_out), model_carry(int'(data_in)));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_q"},     int'(data_out_q),  exp_q);
      check({tag, "_cq"},    int'(carry_out_q), exp_cq);
      check({tag, "_valid"}, int'(valid_q),     exp_v);
   endtask

   // drive inputs mid-cycle, then advance through one rising edge and update the model
   task automatic step(input logic e, input logic [15:0] d);
      @(negedge clk);
      en      = e;
      data_in = d;
      @(posedge clk);
      if (e) begin
         exp_q  = model_out(int'(d));
         exp_cq = model_carry(int'(d));
         exp_v  = 1;
      end
      #1;
   endtask

   initial begin
      logic [15:0] r;
      logic        re;

      // power-up in reset
      rst_n   = 1'b0;
      en      = 1'b1;
      data_in = 16'h1357;
      exp_q = 0; exp_cq = 0; exp_v = 0;
      #3;
      check_regs("pwrup");
      check("pwrup_out", int'(data_out), 16'h26AE);
      @(posedge clk);
      #1;
      check_regs("pwrup_edge");

      // release between edges with en low
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b1;

      // directed: 1000 -> 2000
      data_in = 16'd1000;
      #100;
      check("d1000_out", int'(data_out), 2000);
      check("d1000_carry", int'(carry_out), 0);
      check_regs("d1000_pre");
      step(1'b1, 16'd1000);
      check("d1000_q", int'(data_out_q), 2000);
      check("d1000_valid", int'(valid_q), 1);
      check_regs("d1000");

      // boundaries
      en = 1'b0;
      data_in = 16'h8001; #1;
      check("b8001_out", int'(data_out), 16'h0002);
      check("b8001_carry", int'(carry_out), 1);
      data_in = 16'hFFFF; #1;
      check("bffff_out", int'(data_out), 16'hFFFE);
      check("bffff_carry", int'(carry_out), 1);
      data_in = 16'h0000; #1;
      check("b0000_out", int'(data_out), 0);
      check("b0000_carry", int'(carry_out), 0);

      // exhaustive combinational sweep (en low, registers must hold)
      for (int i = 0; i < 65536; i++) begin
         data_in = 16'(i);
         #1;
         check_comb("sweep");
      end
      check_regs("after_sweep");

      // hold with en low while data_in changes
      step(1'b1, 16'h0010);
      check_regs("hold_cap");
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 16'h0020);
         check_regs("hold");
         check("hold_comb", int'(data_out), 16'h0040);
      end

      // asynchronous reset between edges
      step(1'b1, 16'h091A);
      check("pre_rst_q", int'(data_out_q), 16'h1234);
      check("pre_rst_valid", int'(valid_q), 1);
      @(negedge clk);
      en = 1'b1;
      #1;
      rst_n = 1'b0;
      exp_q = 0; exp_cq = 0; exp_v = 0;
      #1;
      check_regs("async_rst");
      check_comb("async_rst_comb");
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 16'hC3A5);
      check_regs("post_rst");

      // randomized traffic against the reference model
      for (int k = 0; k < 300; k++) begin
         r  = 16'($urandom);
         re = 1'($urandom_range(0, 1));
         step(re, r);
         check_comb("rand");
         check_regs("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
